// File: rtl/tug_of_war_controller_if.sv
// Player press pulses in, LED field / score / match status out.
interface tug_of_war_controller_if #(
  parameter int FIELD_W = 9
);
  logic               left_press;
  logic               right_press;
  logic [FIELD_W-1:0] leds;
  logic [3:0]         left_score;
  logic [3:0]         right_score;
  logic [1:0]         round_winner;
  logic               match_over;

  modport master (
    output left_press, right_press,
    input  leds, left_score, right_score, round_winner, match_over
  );

  modport slave (
    input  left_press, right_press,
    output leds, left_score, right_score, round_winner, match_over
  );
endinterface

// File: rtl/tug_of_war_controller.sv
// Purpose: two-player tug-of-war sequencer (arbitration, position, scoring, hold, match end).
// Latency: a press sampled at edge k is reflected on the registered outputs right after edge k.
// Backpressure: none; presses in HOLD/DONE or lost to a conflict are dropped. Option macro: FAIR_ARB_EN.
module tug_of_war_controller #(
  parameter int FIELD_W     = 9,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  tug_of_war_controller_if.slave  bus
);

  localparam int PW = 4;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0]      POS_C     = PW'((FIELD_W - 1) / 2);
  localparam logic [PW-1:0]      POS_MAX   = PW'(FIELD_W - 1);
  localparam logic [HW-1:0]      HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]         WIN       = 4'(WIN_SCORE);
  localparam logic [FIELD_W-1:0] LED_ONE   = {{(FIELD_W-1){1'b0}}, 1'b1};
  localparam logic [FIELD_W-1:0] LEDS_C    = LED_ONE << POS_C;

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [FIELD_W-1:0] leds_q, leds_d;
  logic [3:0]         left_score_q, left_score_d;
  logic [3:0]         right_score_q, right_score_d;
  logic [1:0]         round_winner_q, round_winner_d;
  logic               match_over_q, match_over_d;

  logic               mv_left, mv_right;
  logic               win;
  logic [3:0]         win_score;

`ifdef FAIR_ARB_EN
  // token 0 = left holds priority on the next conflict
  logic token_q, token_d;

  always_comb begin
    mv_left  = bus.left_press;
    mv_right = bus.right_press;
    token_d  = token_q;
    if (bus.left_press && bus.right_press) begin
      mv_left  = ~token_q;
      mv_right = token_q;
      if (state_q == S_PLAY) begin
        token_d = ~token_q;
      end
    end
  end
`else
  always_comb begin
    mv_left  = bus.left_press & ~bus.right_press;
    mv_right = bus.right_press & ~bus.left_press;
  end
`endif

  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    hold_d         = hold_q;
    left_score_d   = left_score_q;
    right_score_d  = right_score_q;
    round_winner_d = round_winner_q;
    match_over_d   = match_over_q;
    win            = 1'b0;
    win_score      = 4'd0;

    case (state_q)
      S_PLAY: begin
        if (mv_left) begin
          if (pos_q == POS_MAX) begin
            win            = 1'b1;
            left_score_d   = left_score_q + 4'd1;
            win_score      = left_score_d;
            round_winner_d = 2'b01;
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end else if (mv_right) begin
          if (pos_q == '0) begin
            win            = 1'b1;
            right_score_d  = right_score_q + 4'd1;
            win_score      = right_score_d;
            round_winner_d = 2'b10;
          end else begin
            pos_d = pos_q - 4'd1;
          end
        end
        if (win) begin
          if (win_score == WIN) begin
            state_d      = S_DONE;
            match_over_d = 1'b1;
          end else begin
            state_d = S_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d        = S_PLAY;
          pos_d          = POS_C;
          round_winner_d = 2'b00;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      S_DONE: begin
      end
      default: begin
        state_d = S_PLAY;
        pos_d   = POS_C;
      end
    endcase

    // LEDs follow the next state so the lit position appears on the same edge as the move
    leds_d = (state_d == S_PLAY) ? (LED_ONE << pos_d) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_PLAY;
      pos_q          <= POS_C;
      hold_q         <= '0;
      leds_q         <= LEDS_C;
      left_score_q   <= 4'd0;
      right_score_q  <= 4'd0;
      round_winner_q <= 2'b00;
      match_over_q   <= 1'b0;
`ifdef FAIR_ARB_EN
      token_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      hold_q         <= hold_d;
      leds_q         <= leds_d;
      left_score_q   <= left_score_d;
      right_score_q  <= right_score_d;
      round_winner_q <= round_winner_d;
      match_over_q   <= match_over_d;
`ifdef FAIR_ARB_EN
      token_q        <= token_d;
`endif
    end
  end

  assign bus.leds         = leds_q;
  assign bus.left_score   = left_score_q;
  assign bus.right_score  = right_score_q;
  assign bus.round_winner = round_winner_q;
  assign bus.match_over   = match_over_q;

endmodule

// File: tb/tb_tug_of_war_controller.sv
// Bench for tug_of_war_controller: vector table through a scoreboard queue, plus async-reset sequences.
module tb_tug_of_war_controller;

  localparam logic [8:0] CEN = 9'b000010000;

  typedef struct packed {
    logic [8:0] leds;
    logic [3:0] ls;
    logic [3:0] rs;
    logic [1:0] rw;
    logic       mo;
  } out_t;

  typedef struct {
    logic lp;
    logic rp;
    out_t exp;
  } vec_t;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  out_t sb[$];
  vec_t vecs[$];

  tug_of_war_controller_if #(.FIELD_W(9)) bus();

  tug_of_war_controller #(
    .FIELD_W    (9),
    .WIN_SCORE  (2),
    .HOLD_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  function automatic out_t mk(input logic [8:0] leds, input int ls, input int rs,
                              input logic [1:0] rw, input logic mo);
    out_t o;
    o.leds = leds;
    o.ls   = 4'(ls);
    o.rs   = 4'(rs);
    o.rw   = rw;
    o.mo   = mo;
    return o;
  endfunction

  function automatic out_t cur();
    out_t o;
    o.leds = bus.leds;
    o.ls   = bus.left_score;
    o.rs   = bus.right_score;
    o.rw   = bus.round_winner;
    o.mo   = bus.match_over;
    return o;
  endfunction

  task automatic check(input string nm, input out_t e);
    out_t a;
    a = cur();
    total_cnt++;
    if (a === e) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: actual leds=%b ls=%0d rs=%0d rw=%b mo=%b required leds=%b ls=%0d rs=%0d rw=%b mo=%b",
               nm, a.leds, a.ls, a.rs, a.rw, a.mo, e.leds, e.ls, e.rs, e.rw, e.mo);
    end
  endtask

  task automatic add(input logic lp, input logic rp, input logic [8:0] leds, input int ls,
                     input int rs, input logic [1:0] rw, input logic mo);
    vec_t v;
    v.lp  = lp;
    v.rp  = rp;
    v.exp = mk(leds, ls, rs, rw, mo);
    vecs.push_back(v);
  endtask

  task automatic step(input logic lp, input logic rp, input out_t e, input string nm);
    @(negedge clk);
    bus.left_press  = lp;
    bus.right_press = rp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.left_press  = 1'b0;
    bus.right_press = 1'b0;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL %s: actual=empty scoreboard required=entry", nm);
    end else begin
      check(nm, sb.pop_front());
    end
  endtask

  task automatic left_round(input int ls_after, input logic mo, input string nm);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, mk(CEN << (i + 1), ls_after - 1, 0, 2'b00, 1'b0), nm);
    end
    step(1'b1, 1'b0, mk(9'b0, ls_after, 0, 2'b01, mo), nm);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", mk(CEN, 0, 0, 2'b00, 1'b0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    reset           = 1'b0;
    bus.left_press  = 1'b0;
    bus.right_press = 1'b0;

    // moves away from centre and back
    add(1, 0, 9'b000100000, 0, 0, 2'b00, 0);
    add(1, 0, 9'b001000000, 0, 0, 2'b00, 0);
    add(1, 0, 9'b010000000, 0, 0, 2'b00, 0);
    add(0, 1, 9'b001000000, 0, 0, 2'b00, 0);
    add(0, 0, 9'b001000000, 0, 0, 2'b00, 0);
    add(0, 1, 9'b000100000, 0, 0, 2'b00, 0);
    add(0, 1, CEN,          0, 0, 2'b00, 0);
    // simultaneous presses at centre
`ifdef FAIR_ARB_EN
    add(1, 1, 9'b000100000, 0, 0, 2'b00, 0);
    add(1, 1, CEN,          0, 0, 2'b00, 0);
`else
    add(1, 1, CEN,          0, 0, 2'b00, 0);
    add(1, 1, CEN,          0, 0, 2'b00, 0);
`endif
    // left wins a round; presses during HOLD are dropped
    add(1, 0, 9'b000100000, 0, 0, 2'b00, 0);
    add(1, 0, 9'b001000000, 0, 0, 2'b00, 0);
    add(1, 0, 9'b010000000, 0, 0, 2'b00, 0);
    add(1, 0, 9'b100000000, 0, 0, 2'b00, 0);
    add(1, 0, 9'b000000000, 1, 0, 2'b01, 0);
    add(1, 0, 9'b000000000, 1, 0, 2'b01, 0);
    add(0, 1, 9'b000000000, 1, 0, 2'b01, 0);
    add(1, 1, 9'b000000000, 1, 0, 2'b01, 0);
    add(1, 0, CEN,          1, 0, 2'b00, 0);
    add(0, 0, CEN,          1, 0, 2'b00, 0);
    // right wins two rounds and the match
    add(0, 1, 9'b000001000, 1, 0, 2'b00, 0);
    add(0, 1, 9'b000000100, 1, 0, 2'b00, 0);
    add(0, 1, 9'b000000010, 1, 0, 2'b00, 0);
    add(0, 1, 9'b000000001, 1, 0, 2'b00, 0);
    add(0, 1, 9'b000000000, 1, 1, 2'b10, 0);
    add(0, 0, 9'b000000000, 1, 1, 2'b10, 0);
    add(0, 0, 9'b000000000, 1, 1, 2'b10, 0);
    add(0, 0, 9'b000000000, 1, 1, 2'b10, 0);
    add(0, 0, CEN,          1, 1, 2'b00, 0);
    add(0, 1, 9'b000001000, 1, 1, 2'b00, 0);
    add(0, 1, 9'b000000100, 1, 1, 2'b00, 0);
    add(0, 1, 9'b000000010, 1, 1, 2'b00, 0);
    add(0, 1, 9'b000000001, 1, 1, 2'b00, 0);
    add(0, 1, 9'b000000000, 1, 2, 2'b10, 1);
    add(1, 0, 9'b000000000, 1, 2, 2'b10, 1);
    add(0, 1, 9'b000000000, 1, 2, 2'b10, 1);
    add(1, 1, 9'b000000000, 1, 2, 2'b10, 1);
    add(0, 0, 9'b000000000, 1, 2, 2'b10, 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_held", mk(CEN, 0, 0, 2'b00, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_release", mk(CEN, 0, 0, 2'b00, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].lp, vecs[i].rp, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // async reset between edges while in HOLD
    apply_reset();
    left_round(1, 1'b0, "hold_entry");
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_hold", mk(CEN, 0, 0, 2'b00, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, mk(CEN, 0, 0, 2'b00, 1'b0), "after_hold_reset");

    // async reset between edges while in DONE
    left_round(1, 1'b0, "done_r1");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, mk(9'b0, 1, 0, 2'b01, 1'b0), "done_hold");
    end
    step(1'b0, 1'b0, mk(CEN, 1, 0, 2'b00, 1'b0), "done_hold_exit");
    left_round(2, 1'b1, "done_r2");
    step(1'b1, 1'b1, mk(9'b0, 2, 0, 2'b01, 1'b1), "done_frozen");
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_done", mk(CEN, 0, 0, 2'b00, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, mk(9'b000100000, 0, 0, 2'b00, 1'b0), "play_after_done");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
